// File: rtl/sum_pkg.sv
// Shared definitions for the demo adder's operand loader.
//   state_e     : one-hot FSM state encoding of the loader
//   WIDTH_DEF   : default operand width in bits (result is WIDTH+1 bits)
//   TIMEOUT_DEF : default cycle limit for the WAIT state
package sum_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LOAD_B = 5'b00010,
    ISSUE  = 5'b00100,
    WAIT   = 5'b01000,
    HOLD   = 5'b10000
  } state_e;

endpackage

// File: rtl/sum_timeout_ctr.sv
// Saturating cycle counter that supervises the loader's WAIT state.
//   clk     : rising-edge clock
//   rst     : asynchronous, active-high reset
//   clr     : restart the count from zero (takes priority over en)
//   en      : count this cycle
//   expired : high in the cycle whose count brings the total to TIMEOUT,
//             i.e. the TIMEOUT-th enabled cycle since the last clr
module sum_timeout_ctr
  import sum_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0]   LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      // Saturate at TIMEOUT so the count can never wrap back to a small value.
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The increment happening this cycle is the one that reaches TIMEOUT.
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/sum_operand_loader.sv
// Upstream stage of the demo adder: gathers operand A then operand B from a
// byte stream, offers them to the sum stage, captures the returned sum and
// holds it until the consumer takes it. Supervises the wait for the result
// and raises a sticky timeout flag when it does not arrive.
//   clk, rst          : clock and asynchronous active-high reset
//   in_data/in_valid  : operand byte stream; in_ready high in IDLE and LOAD_B
//   op_a/op_b         : operands to the sum stage, valid with op_valid (ISSUE)
//   op_ready          : sum stage takes the operands
//   res_data/res_valid: sum result, sampled only in WAIT
//   out_data/out_valid: captured result, valid in HOLD until out_ready
//   busy              : loader is not IDLE
//   err_timeout       : sticky; set when WAIT lasts TIMEOUT cycles
module sum_operand_loader
  import sum_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  input  logic [WIDTH:0]   res_data,
  input  logic             res_valid,
  output logic [WIDTH:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_timeout
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH:0]   out_data_q, out_data_d;
  logic             op_valid_q, op_valid_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             ctr_clr, ctr_en, ctr_expired;

  sum_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (ctr_expired)
  );

  assign ctr_en = (state_q == WAIT);

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    ctr_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = in_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          op_b_d  = in_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_ready) begin
          ctr_clr = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A result arriving in the expiry cycle still wins over the timeout.
        if (res_valid) begin
          out_data_d = res_data;
          state_d    = HOLD;
        end else if (ctr_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The valids are registered copies of the next-state decode, so they line
  // up exactly with the ISSUE and HOLD states without any output glitching.
  assign op_valid_d  = (state_d == ISSUE);
  assign out_valid_d = (state_d == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_data_q  <= '0;
      op_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_data_q  <= out_data_d;
      op_valid_q  <= op_valid_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE) || (state_q == LOAD_B);
  assign busy        = (state_q != IDLE);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_valid    = op_valid_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err_timeout = err_q;

endmodule
